// File: rtl/nspi_pkg.sv
// Shared definitions for the nSPI frame sequencer and its transmitter-side helpers.
//   seq_state_t           : frame sequencer FSM states
//   NSPI_SPI_SIZE_DEFAULT : default bits per SPI word
//   nspi_width()          : index width for n items, never below 1 bit
package nspi_pkg;

    localparam int NSPI_SPI_SIZE_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        DONE
    } seq_state_t;

    function automatic int nspi_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nspi_frame_sequencer_if.sv
// Bundle between the frame sequencer, the frame buffer and the SPI transmitter.
//   frame_start/frame_busy/frame_done : frame request and status
//   rd_en/rd_addr/rd_data             : frame buffer read port (data one cycle after rd_en)
//   tx_data/tx_start/tx_finish        : transmitter word, start strobe, finish status
//   tx_error                          : sticky watchdog flag
// master = sequencer side, slave = buffer/transmitter/host side.
interface nspi_frame_sequencer_if
    import nspi_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 3,
    parameter int SPI_SIZE       = NSPI_SPI_SIZE_DEFAULT,
    parameter int ADDR_WIDTH     = 9
);
    logic                                     frame_start;
    logic                                     frame_busy;
    logic                                     frame_done;
    logic                                     rd_en;
    logic [ADDR_WIDTH-1:0]                    rd_addr;
    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  rd_data;
    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]  tx_data;
    logic                                     tx_start;
    logic                                     tx_finish;
    logic                                     tx_error;

    modport master (
        input  frame_start, rd_data, tx_finish,
        output frame_busy, frame_done, rd_en, rd_addr, tx_data, tx_start, tx_error
    );

    modport slave (
        output frame_start, rd_data, tx_finish,
        input  frame_busy, frame_done, rd_en, rd_addr, tx_data, tx_start, tx_error
    );

endinterface

// File: rtl/nspi_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_d        : asynchronous input
//   o_q        : synchronized output; both flops reset to RST_VAL
module nspi_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/nspi_frame_sequencer.sv
// Frame sequencer: walks the frame buffer through one shared address, loads one
// word per channel, starts the SPI transmitter, waits for its finish handshake,
// and after the last word inserts a latch gap before pulsing frame_done.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : nspi_frame_sequencer_if.master (frame control, buffer read, transmitter)
// Optional macro NSPI_SEQ_TIMEOUT_EN: watchdog on the handshake wait states; on
// expiry tx_error is set (sticky until reset) and the frame is aborted. Without
// it tx_error is tied low and the handshake wait is unbounded.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for frame_start, index cleared on exit
// FETCH     | rd_en with rd_addr = index
// LOAD      | capture rd_data into tx_data
// START     | tx_start high for this one cycle
// WAIT_ACK  | wait for synchronized finish to go low
// WAIT_DONE | wait for synchronized finish to go high
// GAP       | GAP_CYCLES idle clocks for the matrices to latch
// DONE      | frame_done pulse
module nspi_frame_sequencer
    import nspi_pkg::*;
#(
    parameter int CHANNEL_NUMBER  = 3,
    parameter int SPI_SIZE        = NSPI_SPI_SIZE_DEFAULT,
    parameter int WORDS_PER_FRAME = 384,
    parameter int GAP_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int ADDR_WIDTH      = nspi_width(WORDS_PER_FRAME)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nspi_frame_sequencer_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORDS_PER_FRAME - 1);
    localparam int                    GAP_W    = nspi_width(GAP_CYCLES);
    localparam int                    GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    seq_state_t                              r_state;
    seq_state_t                              w_next;
    logic                                    w_fin_s;
    logic                                    w_wd_expire;
    logic [ADDR_WIDTH-1:0]                   r_index;
    logic [GAP_W-1:0]                        r_gap_cnt;
    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] r_tx_data;

    nspi_sync2 #(.RST_VAL(1'b1)) u_fin_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.tx_finish),
        .o_q   (w_fin_s)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.frame_start) w_next = FETCH;
            FETCH:     w_next = LOAD;
            LOAD:      w_next = START;
            START:     w_next = WAIT_ACK;
            WAIT_ACK: begin
                if (!w_fin_s)         w_next = WAIT_DONE;
                else if (w_wd_expire) w_next = IDLE;
            end
            WAIT_DONE: begin
                if (w_fin_s) begin
                    if (r_index != LAST_IDX) w_next = FETCH;
                    else if (GAP_CYCLES == 0) w_next = DONE;
                    else w_next = GAP;
                end else if (w_wd_expire) begin
                    w_next = IDLE;
                end
            end
            GAP:       if (r_gap_cnt == '0) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_index   <= '0;
            r_gap_cnt <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == IDLE && w_next == FETCH)
                r_index <= '0;
            else if (r_state == WAIT_DONE && w_next == FETCH)
                r_index <= r_index + ADDR_WIDTH'(1);

            if (r_state == LOAD)
                r_tx_data <= bus.rd_data;

            // Gap runs as a down-counter: GAP_CYCLES cycles in GAP, then DONE.
            if (r_state == WAIT_DONE && w_next == GAP)
                r_gap_cnt <= GAP_W'(GAP_LOAD);
            else if (r_state == GAP && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

`ifdef NSPI_SEQ_TIMEOUT_EN
    localparam int WD_W = nspi_width(TIMEOUT_CYCLES);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_tx_error;
    logic            w_wd_entry;
    logic            w_in_wait;

    assign w_in_wait  = (r_state == WAIT_ACK) || (r_state == WAIT_DONE);
    // Reload on every entry so each wait state gets its own full budget.
    assign w_wd_entry = ((w_next == WAIT_ACK)  && (r_state != WAIT_ACK)) ||
                        ((w_next == WAIT_DONE) && (r_state != WAIT_DONE));
    assign w_wd_expire = w_in_wait && (r_wd_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt   <= '0;
            r_tx_error <= 1'b0;
        end else begin
            if (w_wd_entry)
                r_wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            else if (w_in_wait && r_wd_cnt != '0)
                r_wd_cnt <= r_wd_cnt - WD_W'(1);

            // A handshake that completes on the expiry cycle wins over the abort.
            if (w_wd_expire && w_next == IDLE)
                r_tx_error <= 1'b1;
        end
    end

    assign bus.tx_error = r_tx_error;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_wd_expire      = 1'b0;
    assign bus.tx_error     = 1'b0;
`endif

    assign bus.frame_busy = (r_state != IDLE);
    assign bus.frame_done = (r_state == DONE);
    assign bus.rd_en      = (r_state == FETCH);
    assign bus.rd_addr    = r_index;
    assign bus.tx_start   = (r_state == START);
    assign bus.tx_data    = r_tx_data;

endmodule

// File: tb/tb_nspi_frame_sequencer.sv
// Self-checking bench for nspi_frame_sequencer.
// Instance A: 6 words/frame, 16-cycle gap, driven by a behavioural buffer and
// transmitter. Instance B: 1 word/frame, no gap, 64-cycle watchdog, driven directly.
module tb_nspi_frame_sequencer;

    localparam int CH    = 3;
    localparam int SZ    = 8;
    localparam int A_W   = 6;
    localparam int A_GAP = 16;
    localparam int A_AW  = 3;
    localparam int B_AW  = 1;
    localparam int SYNC_RISE_TO_START = 5;  // 2 sync edges + WAIT_DONE exit, FETCH, LOAD
    localparam int SYNC_RISE_TO_EXIT  = 2;  // edges until WAIT_DONE sees fin_s high

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    nspi_frame_sequencer_if #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .ADDR_WIDTH(A_AW)) a_bus ();
    nspi_frame_sequencer_if #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .ADDR_WIDTH(B_AW)) b_bus ();

    nspi_frame_sequencer #(
        .CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .WORDS_PER_FRAME(A_W),
        .GAP_CYCLES(A_GAP), .TIMEOUT_CYCLES(1024), .ADDR_WIDTH(A_AW)
    ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a_bus));

    nspi_frame_sequencer #(
        .CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .WORDS_PER_FRAME(1),
        .GAP_CYCLES(0), .TIMEOUT_CYCLES(64), .ADDR_WIDTH(B_AW)
    ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b_bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural frame buffers: data valid the cycle after rd_en, junk otherwise.
    logic [23:0] a_mem [A_W];
    logic [23:0] b_word;

    always @(posedge clk) begin
        if (a_bus.rd_en && int'(a_bus.rd_addr) < A_W)
            a_bus.rd_data <= a_mem[int'(a_bus.rd_addr)];
        else
            a_bus.rd_data <= 24'($urandom);
        b_bus.rd_data <= b_bus.rd_en ? b_word : 24'($urandom);
    end

    // Monitor and transmitter model for instance A, evaluated at the falling edge.
    int          addr_q[$];
    int          start_cyc_q[$];
    int          rise_cyc_q[$];
    int          done_cyc_q[$];
    logic [23:0] start_data_q[$];
    int          hold_cfg = 0;
    int          stab_err = 0;
    int          overlap_err = 0;
    int          xm_left = 0;
    bit          xm_busy = 1'b0;
    logic [23:0] xm_data;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            xm_busy         = 1'b0;
            a_bus.tx_finish = 1'b1;
        end else begin
            if (a_bus.rd_en)      addr_q.push_back(int'(a_bus.rd_addr));
            if (a_bus.frame_done) done_cyc_q.push_back(cyc);
            if (xm_busy) begin
                if (a_bus.tx_start) overlap_err++;
                if (a_bus.tx_data !== xm_data) stab_err++;
                xm_left--;
                if (xm_left == 0) begin
                    a_bus.tx_finish = 1'b1;
                    xm_busy         = 1'b0;
                    rise_cyc_q.push_back(cyc);
                end
            end else if (a_bus.tx_start) begin
                start_cyc_q.push_back(cyc);
                start_data_q.push_back(a_bus.tx_data);
                xm_data         = a_bus.tx_data;
                xm_busy         = 1'b1;
                xm_left         = (hold_cfg == 0) ? int'($urandom_range(2, 12)) : hold_cfg;
                a_bus.tx_finish = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic clear_logs();
        addr_q.delete();
        start_cyc_q.delete();
        rise_cyc_q.delete();
        done_cyc_q.delete();
        start_data_q.delete();
        stab_err    = 0;
        overlap_err = 0;
    endtask

    task automatic wait_done(input int count, input string tag);
        int n = 0;
        while (done_cyc_q.size() < count && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_wait"}, count, done_cyc_q.size() >= count, 1);
    endtask

    // One frame on instance A, checked against the word-by-word reference.
    task automatic run_frame(input int hold, input bit mid_pulse, input string tag);
        int req;
        bit pulsed = 1'b0;
        int n = 0;
        clear_logs();
        hold_cfg = hold;
        a_bus.frame_start = 1'b1;
        req = cyc;
        tick();
        a_bus.frame_start = 1'b0;
        while (done_cyc_q.size() == 0 && n < 3000) begin
            if (mid_pulse && !pulsed && start_cyc_q.size() >= 2) begin
                a_bus.frame_start = 1'b1;
                tick();
                a_bus.frame_start = 1'b0;
                pulsed = 1'b1;
            end
            tick();
            n++;
        end
        chk({tag, "_wait"}, 0, done_cyc_q.size() != 0, 1);
        repeat (40) tick();

        chk({tag, "_starts"}, 0, start_cyc_q.size(), A_W);
        chk({tag, "_reads"},  0, addr_q.size(), A_W);
        chk({tag, "_dones"},  0, done_cyc_q.size(), 1);
        if (start_cyc_q.size() > 0)
            chk({tag, "_start_lat"}, 0, start_cyc_q[0] - req, 3);
        for (int k = 0; k < A_W; k++) begin
            if (k < addr_q.size())       chk({tag, "_addr"}, k, addr_q[k], k);
            if (k < start_data_q.size()) chk({tag, "_data"}, k, start_data_q[k], a_mem[k]);
            if (k + 1 < start_cyc_q.size() && k < rise_cyc_q.size())
                chk({tag, "_restart"}, k, start_cyc_q[k+1] - rise_cyc_q[k], SYNC_RISE_TO_START);
        end
        if (done_cyc_q.size() > 0 && rise_cyc_q.size() == A_W)
            chk({tag, "_gap"}, 0, done_cyc_q[0] - rise_cyc_q[A_W-1], SYNC_RISE_TO_EXIT + A_GAP + 1);
        chk({tag, "_stable"},  0, stab_err, 0);
        chk({tag, "_overlap"}, 0, overlap_err, 0);
        chk({tag, "_busy"},    0, a_bus.frame_busy, 0);
        chk({tag, "_err"},     0, a_bus.tx_error, 0);
    endtask

    task automatic fill_mem();
        for (int k = 0; k < A_W; k++) a_mem[k] = 24'($urandom);
    endtask

    initial begin
        int n;
        int m;
        int rise;
        int done_seen;

        rst_n             = 1'b0;
        a_bus.frame_start = 1'b0;
        b_bus.frame_start = 1'b0;
        b_bus.tx_finish   = 1'b1;
        b_word            = 24'h123456;
        fill_mem();
        repeat (3) tick();

        // Reset values
        chk("rst_busy",  0, a_bus.frame_busy, 0);
        chk("rst_done",  0, a_bus.frame_done, 0);
        chk("rst_rden",  0, a_bus.rd_en, 0);
        chk("rst_start", 0, a_bus.tx_start, 0);
        chk("rst_err",   0, a_bus.tx_error, 0);
        chk("rst_addr",  0, a_bus.rd_addr, 0);
        chk("rst_data",  0, a_bus.tx_data, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic word: known per-channel bytes at address 0
        a_mem[0] = {8'hFF, 8'h3C, 8'hA5};
        run_frame(0, 1'b0, "basic");
        if (start_data_q.size() > 0)
            chk("basic_word0", 0, start_data_q[0], 24'hFF3CA5);

        // Handshake hold: transmitter keeps finish low for 20 cycles per word
        fill_mem();
        run_frame(20, 1'b0, "hold20");

        // Random data and random transmitter times
        for (int f = 0; f < 3; f++) begin
            fill_mem();
            run_frame(0, 1'b0, "random");
        end

        // Request while busy is dropped
        fill_mem();
        run_frame(0, 1'b1, "ignored_req");

        // Held request gives back-to-back frames
        clear_logs();
        hold_cfg = 0;
        a_bus.frame_start = 1'b1;
        wait_done(1, "held1");
        tick();
        chk("held_idle_busy", 0, a_bus.frame_busy, 0);
        tick();
        chk("held_refetch", 0, a_bus.rd_en, 1);
        chk("held_addr0",   0, a_bus.rd_addr, 0);
        a_bus.frame_start = 1'b0;
        wait_done(2, "held2");
        repeat (40) tick();
        chk("held_starts", 0, start_cyc_q.size(), 2 * A_W);
        chk("held_dones",  0, done_cyc_q.size(), 2);

        // Reset during WAIT_ACK of word 5
        clear_logs();
        fill_mem();
        hold_cfg = 0;
        a_bus.frame_start = 1'b1;
        tick();
        a_bus.frame_start = 1'b0;
        n = 0;
        while (start_cyc_q.size() < 6 && n < 3000) begin
            tick();
            n++;
        end
        chk("rstmid_reach", 0, start_cyc_q.size() >= 6, 1);
        tick();
        chk("rstmid_busy_pre", 0, a_bus.frame_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_start", 0, a_bus.tx_start, 0);
        chk("rstmid_busy",  0, a_bus.frame_busy, 0);
        chk("rstmid_rden",  0, a_bus.rd_en, 0);
        chk("rstmid_data",  0, a_bus.tx_data, 0);
        chk("rstmid_addr",  0, a_bus.rd_addr, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("rstmid_nodone", 0, done_cyc_q.size(), 0);
        fill_mem();
        run_frame(0, 1'b0, "post_reset");

        // Instance B: single word, no gap
        tick();
        b_bus.frame_start = 1'b1;
        m = cyc;
        tick();
        b_bus.frame_start = 1'b0;
        chk("b_rden", 0, b_bus.rd_en, 1);
        chk("b_addr", 0, b_bus.rd_addr, 0);
        tick();
        tick();
        chk("b_start_lat", 0, cyc - m, 3);
        chk("b_start", 0, b_bus.tx_start, 1);
        chk("b_data",  0, b_bus.tx_data, 24'h123456);
        b_bus.tx_finish = 1'b0;
        repeat (4) tick();
        b_bus.tx_finish = 1'b1;
        rise = cyc;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("b_done_at", k, b_bus.frame_done, (cyc == rise + SYNC_RISE_TO_EXIT + 1) ? 1 : 0);
        end
        tick();
        chk("b_done_end", 0, b_bus.frame_done, 0);
        chk("b_idle",     0, b_bus.frame_busy, 0);
        chk("b_err",      0, b_bus.tx_error, 0);

`ifdef NSPI_SEQ_TIMEOUT_EN
        // Watchdog: finish stuck high, 64 cycles in WAIT_ACK then abort
        b_word = 24'hC0FFEE;
        b_bus.frame_start = 1'b1;
        tick();
        b_bus.frame_start = 1'b0;
        tick();
        tick();
        chk("wd_start", 0, b_bus.tx_start, 1);
        done_seen = 0;
        repeat (64) begin
            tick();
            if (b_bus.frame_done) done_seen++;
        end
        chk("wd_err_pre",  0, b_bus.tx_error, 0);
        chk("wd_busy_pre", 0, b_bus.frame_busy, 1);
        tick();
        chk("wd_err",  0, b_bus.tx_error, 1);
        chk("wd_busy", 0, b_bus.frame_busy, 0);
        chk("wd_data", 0, b_bus.tx_data, 24'hC0FFEE);
        repeat (20) begin
            tick();
            if (b_bus.frame_done) done_seen++;
        end
        chk("wd_nodone", 0, done_seen, 0);
        chk("wd_sticky", 0, b_bus.tx_error, 1);
        rst_n = 1'b0;
        #1;
        chk("wd_clear", 0, b_bus.tx_error, 0);
        tick();
        rst_n = 1'b1;
        tick();
`else
        done_seen = 0;
        m = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
